cotm32_trap_csr: RTL and testbench
==================================

# cotm32_trap_csr

Machine-mode CSR file and trap controller for the cotm32 core. It holds the M-mode trap CSRs, counts cycles and retired instructions, prioritises interrupts, and computes redirect targets for trap entry and `mret`. It generalises the fixed trap/CSR definitions to a configurable set of platform-local interrupts (cause 16+i), vectored `mtvec` mode and 64-bit counters. It sits beside the execute stage: the core issues CSR accesses, exceptions, interrupt acknowledges and `mret` into it.

## Interface
- `NUM_LOCAL_IRQ`, 4: number of platform-local interrupts (0..16), mapped to `mie`/`mip` bits 16+i.
- `RESET_MTVEC`, 32'h0000_0000: reset value of `mtvec`, including the mode bits.
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `csr_op` in 2: `zicsr_csr_op_t` (NONE/RW/RS/RC).
- `csr_addr` in 12: CSR address.
- `csr_wdata` in 32: rs1 value or zero-extended immediate.
- `csr_rdata` out 32: combinational old value of the addressed CSR.
- `csr_illegal` out 1: combinational; op≠NONE and the address is not implemented.
- `exc_valid` in 1: synchronous exception this cycle.
- `exc_cause` in 32: `trap_cause_t`.
- `exc_pc` in 32: PC of the faulting instruction, or of the interrupted instruction on `irq_ack`.
- `exc_tval` in 32: trap value.
- `irq_ack` in 1: core takes the pending interrupt at this instruction boundary.
- `mret` in 1: `mret` executes this cycle.
- `irq_sw`, `irq_timer`, `irq_ext` in 1 each: level interrupt lines.
- `irq_local` in `NUM_LOCAL_IRQ`: level local interrupt lines.
- `inst_retire` in 1: one instruction retires this cycle.
- `irq_req` out 1: `mstatus.mie` & |(`mip` & `mie`).
- `redirect_valid` out 1: combinational; `exc_valid` | `irq_ack` | `mret`.
- `redirect_pc` out 32: combinational PC target.

## Operation
- **Implemented CSRs**
  - `mstatus`: only MIE and MPIE are writable; all other bits read 0.
  - `mie`: bits 3, 7, 11 and 16+i are writable; all other bits read 0.
  - `mtvec`: mode is WARL. A write with mode ≥2 keeps the old mode and still updates the base.
  - `mepc`: bits [1:0] read 0.
  - `mcause`, `mtval`: full 32 bits writable.
  - `mip`: read-only; writes are ignored and are not illegal.
  - `mcycle`/`mcycleh` (B00/B80) and `minstret`/`minstreth` (B02/B82): writable.
- **CSR write value**: RW gives wdata; RS gives old|wdata; RC gives old&~wdata; NONE does not write. An illegal access changes no state.
- **mip sampling**: lines are registered every cycle, giving 1-cycle latency from pin to `mip`.
- **Interrupt priority**: highest local index first, then MEI, MSI, MTI. The selected cause is `{1'b1, code}`.
- **Trap entry** (`exc_valid`, or `irq_ack` with `irq_req`), on the clock edge:
  - `mepc` ← `exc_pc`&~3.
  - `mcause` ← cause.
  - `mtval` ← `exc_tval` for exceptions, 0 for interrupts.
  - MPIE ← MIE, then MIE ← 0.
- **`mret`** (clock edge): MIE ← MPIE, MPIE ← 1.
- **`redirect_pc`**:
  - Trap: base, or base + 4·code when the trap is an interrupt and mode = 1.
  - `mret`: `mepc`.
- **Counters**: `mcycle` increments every cycle. `minstret` increments when `inst_retire` is high. Both are 64-bit and wrap at 2^64. A CSR write to either half overrides the increment of the whole counter in that cycle; the other half holds.
- **Simultaneous events**, in priority order: `exc_valid` > `irq_ack` > `mret` > CSR write. Only the highest-priority event updates trap state; lower-priority events are dropped. `irq_ack` while `irq_req`=0 is ignored and drives no redirect.

## Timing
- Reset: all CSRs are 0 except `mtvec`=`RESET_MTVEC`. Immediately after reset `irq_req`=0 and `redirect_valid`=0.
- `csr_rdata`, `csr_illegal`, `irq_req`, `redirect_*`: combinational, zero latency.
- CSR writes and trap updates become visible to reads the next cycle.
- A reset asserted during trap entry wins: all state returns to reset values.
- Latency from interrupt pin to `irq_req`: 1 cycle.

## Structure
- Additions to `cotm32_priv_pkg`:
  - CSR address constants for mcycle, mcycleh, minstret, minstreth.
  - `mtvec` mode enum (DIRECT = 0, VECTORED = 1).
  - `mie`/`mip` struct widths extended to bit 31.
  - `LOCAL_IRQ_BASE = 16`.
- Sub-module `cotm32_irq_arbiter`: priority encoder that takes the pending & enabled vector and produces valid plus a 31-bit code.

## Test plan
- After reset: read every CSR → 0, except `mtvec` = `RESET_MTVEC`; read 0x7C0 → `csr_illegal`=1.
- CSRRS `mie` with 0x888, then CSRRC with 0x008 → reads back 0x880. CSRRW `mstatus` with 0xFFFFFFFF → reads back 0x88.
- `mtvec`=0x1001 (vectored), MIE=1, MTIE=1, pulse `irq_timer` → `irq_req` rises 1 cycle later. Then `irq_ack` with `exc_pc`=0x200 → `redirect_pc`=0x101C; next cycle `mcause`=0x80000007, `mepc`=0x200, MIE=0, MPIE=1.
- `exc_valid` (cause 2, tval 0xDEAD) in the same cycle as `irq_ack` and a CSR write → only the exception is taken: `mtval`=0xDEAD, `redirect_pc` = `mtvec` base, CSR write dropped.
- `mret` → `redirect_pc`=`mepc`; next cycle MIE=1, MPIE=1.
- Write `mcycle`=0xFFFFFFFF and `mcycleh`=0xFFFFFFFF → counter wraps to 0 the following cycle. Write to `minstret` while `inst_retire`=1 → read back equals the written value.

Source files
------------

// File: rtl/cotm32_priv_pkg.sv
// Shared machine-mode privileged definitions for the cotm32 core:
// CSR addresses, trap cause layout, mtvec modes and interrupt bit positions.
package cotm32_priv_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } zicsr_csr_op_t;

    typedef struct packed {
        logic        interrupt;
        logic [30:0] code;
    } trap_cause_t;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'd0,
        MTVEC_VECTORED = 2'd1
    } mtvec_mode_t;

    // mie/mip layout, platform-local interrupts occupy bits 31:16
    typedef struct packed {
        logic [15:0] local_irq;
        logic [3:0]  rsvd_15_12;
        logic        mei;
        logic [2:0]  rsvd_10_8;
        logic        mti;
        logic [2:0]  rsvd_6_4;
        logic        msi;
        logic [2:0]  rsvd_2_0;
    } irq_vec_t;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int LOCAL_IRQ_BASE = 16;
    localparam int IRQ_MSI        = 3;
    localparam int IRQ_MTI        = 7;
    localparam int IRQ_MEI        = 11;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;

endpackage

// File: rtl/cotm32_irq_arbiter.sv
// Fixed-priority interrupt selector: highest local index, then MEI, MSI, MTI.
module cotm32_irq_arbiter
    import cotm32_priv_pkg::*;
#(
    parameter int NUM_LOCAL_IRQ = 4
) (
    input  logic [31:0] pending,
    output logic        valid,
    output logic [30:0] code
);

    // pending is already masked to implemented bits, so any set bit is a request
    assign valid = |pending;

    always_comb begin
        code = '0;
        if (pending[IRQ_MTI]) code = 31'(IRQ_MTI);
        if (pending[IRQ_MSI]) code = 31'(IRQ_MSI);
        if (pending[IRQ_MEI]) code = 31'(IRQ_MEI);
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            if (pending[LOCAL_IRQ_BASE + i]) code = 31'(LOCAL_IRQ_BASE + i);
        end
    end

endmodule

// File: rtl/cotm32_trap_csr.sv
// Machine-mode CSR file and trap controller: trap CSRs, 64-bit counters,
// interrupt prioritisation and redirect targets for trap entry and mret.
module cotm32_trap_csr
    import cotm32_priv_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  zicsr_csr_op_t            csr_op,
    input  logic [11:0]              csr_addr,
    input  logic [31:0]              csr_wdata,
    output logic [31:0]              csr_rdata,
    output logic                     csr_illegal,
    input  logic                     exc_valid,
    input  trap_cause_t              exc_cause,
    input  logic [31:0]              exc_pc,
    input  logic [31:0]              exc_tval,
    input  logic                     irq_ack,
    input  logic                     mret,
    input  logic                     irq_sw,
    input  logic                     irq_timer,
    input  logic                     irq_ext,
    input  logic [NUM_LOCAL_IRQ-1:0] irq_local,
    input  logic                     inst_retire,
    output logic                     irq_req,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc
);

    logic        mstatus_mie_reg, mstatus_mpie_reg;
    logic [31:0] mie_reg, mip_reg, mepc_reg, mcause_reg, mtval_reg;
    logic [29:0] mtvec_base_reg;
    logic [1:0]  mtvec_mode_reg;
    logic [63:0] mcycle_reg, minstret_reg;

    logic [31:0] irq_mask, irq_lines, csr_new;
    logic        csr_hit, irq_valid, irq_take, mret_take, csr_we;
    logic [30:0] irq_code;

    // Writable mie bits and the raw interrupt lines placed at their mip positions
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_irq_bits
            if (gi == IRQ_MSI) begin : g_msi
                assign irq_mask[gi]  = 1'b1;
                assign irq_lines[gi] = irq_sw;
            end else if (gi == IRQ_MTI) begin : g_mti
                assign irq_mask[gi]  = 1'b1;
                assign irq_lines[gi] = irq_timer;
            end else if (gi == IRQ_MEI) begin : g_mei
                assign irq_mask[gi]  = 1'b1;
                assign irq_lines[gi] = irq_ext;
            end else if (gi >= LOCAL_IRQ_BASE && gi < LOCAL_IRQ_BASE + NUM_LOCAL_IRQ) begin : g_local
                assign irq_mask[gi]  = 1'b1;
                assign irq_lines[gi] = irq_local[gi - LOCAL_IRQ_BASE];
            end else begin : g_none
                assign irq_mask[gi]  = 1'b0;
                assign irq_lines[gi] = 1'b0;
            end
        end
    endgenerate

    cotm32_irq_arbiter #(
        .NUM_LOCAL_IRQ(NUM_LOCAL_IRQ)
    ) u_irq_arbiter (
        .pending(mip_reg & mie_reg),
        .valid  (irq_valid),
        .code   (irq_code)
    );

    assign irq_req   = mstatus_mie_reg & irq_valid;
    assign irq_take  = ~exc_valid & irq_ack & irq_req;
    assign mret_take = ~exc_valid & ~irq_take & mret;

    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:   begin
                csr_rdata[MSTATUS_MIE]  = mstatus_mie_reg;
                csr_rdata[MSTATUS_MPIE] = mstatus_mpie_reg;
            end
            CSR_MIE:       csr_rdata = mie_reg;
            CSR_MTVEC:     csr_rdata = {mtvec_base_reg, mtvec_mode_reg};
            CSR_MEPC:      csr_rdata = mepc_reg;
            CSR_MCAUSE:    csr_rdata = mcause_reg;
            CSR_MTVAL:     csr_rdata = mtval_reg;
            CSR_MIP:       csr_rdata = mip_reg;
            CSR_MCYCLE:    csr_rdata = mcycle_reg[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle_reg[63:32];
            CSR_MINSTRET:  csr_rdata = minstret_reg[31:0];
            CSR_MINSTRETH: csr_rdata = minstret_reg[63:32];
            default:       csr_hit = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            CSR_OP_RW: csr_new = csr_wdata;
            CSR_OP_RS: csr_new = csr_rdata | csr_wdata;
            CSR_OP_RC: csr_new = csr_rdata & ~csr_wdata;
            default:   csr_new = csr_rdata;
        endcase
    end

    assign csr_illegal = (csr_op != CSR_OP_NONE) & ~csr_hit;
    // Any trap or mret in the same cycle suppresses the CSR write
    assign csr_we = (csr_op != CSR_OP_NONE) & csr_hit & ~exc_valid & ~irq_take & ~mret_take;

    always_comb begin
        redirect_valid = exc_valid | irq_take | mret_take;
        redirect_pc    = '0;
        if (exc_valid) begin
            redirect_pc = {mtvec_base_reg, 2'b00};
        end else if (irq_take) begin
            redirect_pc = {mtvec_base_reg, 2'b00};
            if (mtvec_mode_reg == MTVEC_VECTORED)
                redirect_pc = {mtvec_base_reg, 2'b00} + {irq_code[29:0], 2'b00};
        end else if (mret_take) begin
            redirect_pc = mepc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= '0;
            mip_reg          <= '0;
            mtvec_base_reg   <= RESET_MTVEC[31:2];
            mtvec_mode_reg   <= RESET_MTVEC[1:0];
            mepc_reg         <= '0;
            mcause_reg       <= '0;
            mtval_reg        <= '0;
            mcycle_reg       <= '0;
            minstret_reg     <= '0;
        end else begin
            mip_reg    <= irq_lines;
            mcycle_reg <= mcycle_reg + 64'd1;
            if (inst_retire) minstret_reg <= minstret_reg + 64'd1;

            if (exc_valid || irq_take) begin
                mepc_reg         <= exc_pc & ~32'd3;
                mcause_reg       <= exc_valid ? exc_cause : {1'b1, irq_code};
                mtval_reg        <= exc_valid ? exc_tval : 32'd0;
                mstatus_mpie_reg <= mstatus_mie_reg;
                mstatus_mie_reg  <= 1'b0;
            end else if (mret_take) begin
                mstatus_mie_reg  <= mstatus_mpie_reg;
                mstatus_mpie_reg <= 1'b1;
            end else if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie_reg  <= csr_new[MSTATUS_MIE];
                        mstatus_mpie_reg <= csr_new[MSTATUS_MPIE];
                    end
                    CSR_MIE:   mie_reg <= csr_new & irq_mask;
                    CSR_MTVEC: begin
                        mtvec_base_reg <= csr_new[31:2];
                        // Reserved modes leave the previous mode in place
                        if (csr_new[1:0] < 2'd2) mtvec_mode_reg <= csr_new[1:0];
                    end
                    CSR_MEPC:      mepc_reg   <= csr_new & ~32'd3;
                    CSR_MCAUSE:    mcause_reg <= csr_new;
                    CSR_MTVAL:     mtval_reg  <= csr_new;
                    CSR_MCYCLE:    mcycle_reg   <= {mcycle_reg[63:32], csr_new};
                    CSR_MCYCLEH:   mcycle_reg   <= {csr_new, mcycle_reg[31:0]};
                    CSR_MINSTRET:  minstret_reg <= {minstret_reg[63:32], csr_new};
                    CSR_MINSTRETH: minstret_reg <= {csr_new, minstret_reg[31:0]};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cotm32_trap_csr.sv
// Directed self-checking bench for cotm32_trap_csr with hand-computed expectations.
module tb_cotm32_trap_csr;
    import cotm32_priv_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    zicsr_csr_op_t csr_op;
    logic [11:0]   csr_addr;
    logic [31:0]   csr_wdata, csr_rdata;
    logic          csr_illegal;
    logic          exc_valid;
    trap_cause_t   exc_cause;
    logic [31:0]   exc_pc, exc_tval;
    logic          irq_ack, mret, irq_sw, irq_timer, irq_ext;
    logic [3:0]    irq_local;
    logic          inst_retire, irq_req, redirect_valid;
    logic [31:0]   redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    cotm32_trap_csr #(
        .NUM_LOCAL_IRQ(4),
        .RESET_MTVEC  (32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .irq_ack(irq_ack), .mret(mret),
        .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_local(irq_local),
        .inst_retire(inst_retire), .irq_req(irq_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("pass %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input zicsr_csr_op_t op, input logic [11:0] addr, input logic [31:0] data);
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = data;
        step();
        csr_op    = CSR_OP_NONE;
        csr_wdata = '0;
    endtask

    task automatic read_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1;
        check_eq(tag, csr_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; csr_op = CSR_OP_NONE; csr_addr = '0; csr_wdata = '0;
        exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
        irq_ack = 1'b0; mret = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
        irq_local = '0; inst_retire = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state, read in the first cycle after reset
        check_eq("rst_irq_req", {31'd0, irq_req}, 32'd0);
        check_eq("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        read_check("rst_mcycle", CSR_MCYCLE, 32'd0);
        read_check("rst_mcycleh", CSR_MCYCLEH, 32'd0);
        read_check("rst_minstret", CSR_MINSTRET, 32'd0);
        read_check("rst_minstreth", CSR_MINSTRETH, 32'd0);
        read_check("rst_mstatus", CSR_MSTATUS, 32'd0);
        read_check("rst_mie", CSR_MIE, 32'd0);
        read_check("rst_mtvec", CSR_MTVEC, 32'd0);
        read_check("rst_mepc", CSR_MEPC, 32'd0);
        read_check("rst_mcause", CSR_MCAUSE, 32'd0);
        read_check("rst_mtval", CSR_MTVAL, 32'd0);
        read_check("rst_mip", CSR_MIP, 32'd0);
        step();
        read_check("mcycle_incr", CSR_MCYCLE, 32'd1);

        // Illegal address versus read-only mip
        csr_op = CSR_OP_RS; csr_addr = 12'h7C0; #1;
        check_eq("illegal_7c0", {31'd0, csr_illegal}, 32'd1);
        csr_op = CSR_OP_RW; csr_addr = CSR_MIP; #1;
        check_eq("mip_write_legal", {31'd0, csr_illegal}, 32'd0);
        csr_op = CSR_OP_NONE;
        step();

        // Set/clear/write masking
        csr_write(CSR_OP_RS, CSR_MIE, 32'h888);
        csr_write(CSR_OP_RC, CSR_MIE, 32'h008);
        read_check("mie_rs_rc", CSR_MIE, 32'h880);
        csr_write(CSR_OP_RW, CSR_MIE, 32'hFFFF_FFFF);
        read_check("mie_mask", CSR_MIE, 32'h000F_0888);
        csr_write(CSR_OP_RW, CSR_MIE, 32'h80);
        csr_write(CSR_OP_RW, CSR_MSTATUS, 32'hFFFF_FFFF);
        read_check("mstatus_mask", CSR_MSTATUS, 32'h88);
        csr_write(CSR_OP_RW, CSR_MTVEC, 32'h1001);
        read_check("mtvec_vectored", CSR_MTVEC, 32'h1001);
        csr_write(CSR_OP_RW, CSR_MTVEC, 32'h2002);
        read_check("mtvec_warl", CSR_MTVEC, 32'h2001);
        csr_write(CSR_OP_RW, CSR_MTVEC, 32'h1001);

        // Timer interrupt, vectored entry
        irq_timer = 1'b1; #1;
        check_eq("irq_req_latency0", {31'd0, irq_req}, 32'd0);
        step();
        check_eq("irq_req_latency1", {31'd0, irq_req}, 32'd1);
        irq_ack = 1'b1; exc_pc = 32'h200; irq_timer = 1'b0; #1;
        check_eq("irq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check_eq("irq_redirect_pc", redirect_pc, 32'h101C);
        step();
        irq_ack = 1'b0;
        read_check("irq_mcause", CSR_MCAUSE, 32'h8000_0007);
        read_check("irq_mepc", CSR_MEPC, 32'h200);
        read_check("irq_mstatus", CSR_MSTATUS, 32'h80);

        // Exception beats irq_ack and a CSR write in the same cycle
        csr_write(CSR_OP_RS, CSR_MSTATUS, 32'h8);
        irq_timer = 1'b1;
        step();
        check_eq("exc_irq_req", {31'd0, irq_req}, 32'd1);
        exc_valid = 1'b1; exc_cause = trap_cause_t'(32'd2); exc_tval = 32'hDEAD;
        exc_pc = 32'h300; irq_ack = 1'b1;
        csr_op = CSR_OP_RW; csr_addr = CSR_MTVAL; csr_wdata = 32'h1234; #1;
        check_eq("exc_redirect_pc", redirect_pc, 32'h1000);
        step();
        exc_valid = 1'b0; irq_ack = 1'b0; csr_op = CSR_OP_NONE; irq_timer = 1'b0;
        read_check("exc_mtval", CSR_MTVAL, 32'hDEAD);
        read_check("exc_mcause", CSR_MCAUSE, 32'd2);
        read_check("exc_mepc", CSR_MEPC, 32'h300);
        read_check("exc_mstatus", CSR_MSTATUS, 32'h80);

        // mret
        mret = 1'b1; #1;
        check_eq("mret_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check_eq("mret_redirect_pc", redirect_pc, 32'h300);
        step();
        mret = 1'b0;
        read_check("mret_mstatus", CSR_MSTATUS, 32'h88);
        csr_write(CSR_OP_RW, CSR_MEPC, 32'h403);
        read_check("mepc_align", CSR_MEPC, 32'h400);

        // Counters: 64-bit wrap and write-over-increment
        csr_write(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
        csr_write(CSR_OP_RW, CSR_MCYCLEH, 32'hFFFF_FFFF);
        read_check("mcycle_max_lo", CSR_MCYCLE, 32'hFFFF_FFFF);
        read_check("mcycle_max_hi", CSR_MCYCLEH, 32'hFFFF_FFFF);
        step();
        read_check("mcycle_wrap_lo", CSR_MCYCLE, 32'd0);
        read_check("mcycle_wrap_hi", CSR_MCYCLEH, 32'd0);
        inst_retire = 1'b1;
        csr_write(CSR_OP_RW, CSR_MINSTRET, 32'h55);
        inst_retire = 1'b0;
        read_check("minstret_write", CSR_MINSTRET, 32'h55);
        read_check("minstreth_hold", CSR_MINSTRETH, 32'd0);
        inst_retire = 1'b1;
        step();
        inst_retire = 1'b0;
        read_check("minstret_retire", CSR_MINSTRET, 32'h56);

        // Local interrupt outranks MEI; vectored to code 18
        csr_write(CSR_OP_RW, CSR_MIE, 32'h0004_0800);
        irq_ext = 1'b1; irq_local = 4'b0100;
        step();
        check_eq("local_irq_req", {31'd0, irq_req}, 32'd1);
        irq_ack = 1'b1; exc_pc = 32'h506; #1;
        check_eq("local_redirect_pc", redirect_pc, 32'h1048);
        step();
        irq_ack = 1'b0;
        read_check("local_mcause", CSR_MCAUSE, 32'h8000_0012);
        read_check("local_mtval", CSR_MTVAL, 32'd0);
        read_check("local_mepc", CSR_MEPC, 32'h504);

        // irq_ack without a request is ignored
        irq_ack = 1'b1; #1;
        check_eq("ack_no_req_redirect", {31'd0, redirect_valid}, 32'd0);
        step();
        irq_ack = 1'b0; irq_ext = 1'b0; irq_local = '0;
        read_check("ack_no_req_mcause", CSR_MCAUSE, 32'h8000_0012);

        // Reset wins over a simultaneous trap
        exc_valid = 1'b1; exc_cause = trap_cause_t'(32'd5); exc_pc = 32'h700; rst = 1'b1;
        step();
        rst = 1'b0; exc_valid = 1'b0;
        read_check("rst_trap_mcause", CSR_MCAUSE, 32'd0);
        read_check("rst_trap_mepc", CSR_MEPC, 32'd0);
        read_check("rst_trap_mtvec", CSR_MTVEC, 32'd0);
        read_check("rst_trap_mstatus", CSR_MSTATUS, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
